// File: rtl/ram_map_pkg.sv
// Shared-RAM address map, mailbox codes and streamer FSM states.
// Imported by the port-2 streamer; the RAM block and firmware headers use the same values.
// Word addresses are in the slow-domain port-2 address space.
package ram_map_pkg;

    // Shared RAM window and mailbox words (word addresses)
    localparam int unsigned RAM_BASE  = 206800;
    localparam int unsigned RAM_WORDS = 1200;
    localparam int unsigned CTRL_ADDR = 411698;
    localparam int unsigned ARG_ADDR  = 411699;

    // CTRL word: commands written by the CPU, statuses written back by the streamer
    localparam int unsigned CMD_NONE  = 0;
    localparam int unsigned CMD_START = 1;
    localparam int unsigned ST_DONE   = 2;
    localparam int unsigned ST_ERR    = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        STREAM,
        WRITE,
        VERIFY
    } state_t;

endpackage

// File: rtl/ram_block_streamer.sv
// Port-2 SRAM master: polls the mailbox, streams one block to the encoder, writes status back.
// Latency: command seen within POLL_GAP cycles; first word 2 cycles later; 1 word/cycle thereafter.
// Backpressure: m_ready low holds m_data/m_valid/m_last and stops RAM address advance.
module ram_block_streamer
    import ram_map_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 64,
    parameter int POLL_GAP    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_enw,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             err
);

    localparam int PC_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int IX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [WIDTH-1:0] A_CTRL  = WIDTH'(CTRL_ADDR);
    localparam logic [WIDTH-1:0] A_ARG   = WIDTH'(ARG_ADDR);
    localparam logic [WIDTH-1:0] A_BASE  = WIDTH'(RAM_BASE);
    // Largest start index whose block still fits inside the window
    localparam logic [WIDTH-1:0] OFF_MAX = WIDTH'(RAM_WORDS - BLOCK_WORDS);
    localparam logic [WIDTH-1:0] C_START = WIDTH'(CMD_START);
    localparam logic [WIDTH-1:0] C_DONE  = WIDTH'(ST_DONE);
    localparam logic [WIDTH-1:0] C_ERR   = WIDTH'(ST_ERR);
    localparam logic [WIDTH-1:0] A_ONE   = WIDTH'(1);

    localparam logic [PC_W-1:0] POLL_RELOAD = PC_W'(POLL_GAP - 1);
    localparam logic [PC_W-1:0] PC_ONE      = PC_W'(1);
    localparam logic [IX_W-1:0] IX_LAST     = IX_W'(BLOCK_WORDS - 1);
    localparam logic [IX_W-1:0] IX_ONE      = IX_W'(1);

    state_t          state;
    logic [PC_W-1:0] poll_cnt;
    logic [IX_W-1:0] idx;
    logic            slot_free;

    // Output register can take a new word when empty or being drained this cycle
    assign slot_free = !m_valid || m_ready;

    // Mailbox FSM; every port and stream output is registered here.
    // ram_rdata is only consumed in cycles where ram_addr was set up on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            poll_cnt  <= POLL_RELOAD;
            idx       <= '0;
            ram_addr  <= A_CTRL;
            ram_wdata <= '0;
            ram_enw   <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    ram_addr <= A_CTRL;
                    if (poll_cnt == '0) begin
                        poll_cnt <= POLL_RELOAD;
                        if (ram_rdata == C_START) begin
                            ram_addr <= A_ARG;
                            busy     <= 1'b1;
                            state    <= ARG;
                        end
                    end else begin
                        poll_cnt <= poll_cnt - PC_ONE;
                    end
                end
                ARG: begin
                    // Unsigned compare: "negative" offsets are rejected too
                    if (ram_rdata > OFF_MAX) begin
                        err       <= 1'b1;
                        ram_wdata <= C_ERR;
                        state     <= WRITE;
                    end else begin
                        ram_addr <= A_BASE + ram_rdata;
                        idx      <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (m_valid && m_last) begin
                        // Whole block loaded: only wait for the last word to drain
                        if (m_ready) begin
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            ram_wdata <= C_DONE;
                            state     <= WRITE;
                        end
                    end else if (slot_free) begin
                        m_data   <= ram_rdata;
                        m_valid  <= 1'b1;
                        m_last   <= (idx == IX_LAST);
                        ram_addr <= ram_addr + A_ONE;
                        idx      <= idx + IX_ONE;
                    end
                end
                WRITE: begin
                    // enw is high for exactly the first VERIFY cycle
                    ram_addr <= A_CTRL;
                    ram_enw  <= 1'b1;
                    state    <= VERIFY;
                end
                VERIFY: begin
                    if (ram_enw) begin
                        // Write cycle doubles as the address-setup cycle for the read-back
                        ram_enw <= 1'b0;
                    end else if (ram_rdata == C_START) begin
                        // Status lost to a colliding port-1 write: resend the same word
                        state <= WRITE;
                    end else begin
                        poll_cnt <= POLL_RELOAD;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_streamer.sv
// Directed bench for ram_block_streamer with a behavioural shared-RAM/mailbox model.
// Table of block transactions plus hand sequences for reset, idle polling and mid-stream reset.
// Downstream ready is driven per-cycle from the vector's ready percentage.
module tb_ram_block_streamer;
    import ram_map_pkg::*;

    localparam int W     = 32;
    localparam int BW    = 64;
    localparam int PGAP  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  ram_addr;
    logic [W-1:0]  ram_wdata;
    logic          ram_enw;
    logic [W-1:0]  ram_rdata;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          err;

    ram_block_streamer #(.WIDTH(W), .BLOCK_WORDS(BW), .POLL_GAP(PGAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_enw   (ram_enw),
        .ram_rdata (ram_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ---------------- RAM / mailbox model ----------------
    logic [W-1:0] mem [0:RAM_WORDS-1];
    logic [W-1:0] ctrl     = '0;
    logic [W-1:0] arg_word = '0;
    logic         cpu_wr   = 1'b0;
    logic [W-1:0] cpu_val  = '0;
    int           wr_total = 0;
    int           bad_wr   = 0;
    int           drop_idx = -1;
    logic [W-1:0] rd_off;

    function automatic logic [W-1:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0000_5A5A;
    endfunction

    always_comb begin
        ram_rdata = 32'hDEAD_BEEF;
        rd_off    = ram_addr - 32'(RAM_BASE);
        if (ram_addr == 32'(CTRL_ADDR))
            ram_rdata = ctrl;
        else if (ram_addr == 32'(ARG_ADDR))
            ram_rdata = arg_word;
        else if (rd_off < 32'(RAM_WORDS))
            ram_rdata = mem[rd_off[10:0]];
    end

    always @(posedge clk) begin
        if (cpu_wr) begin
            ctrl <= cpu_val;
        end else if (ram_enw) begin
            if (ram_addr == 32'(CTRL_ADDR)) begin
                if (wr_total != drop_idx)
                    ctrl <= ram_wdata;
                wr_total <= wr_total + 1;
            end else begin
                bad_wr <= bad_wr + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [W-1:0] v);
        cpu_val = v;
        cpu_wr  = 1'b1;
        tick();
        cpu_wr  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"},  ram_addr,  32'(CTRL_ADDR));
        chk({tag, "_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_enw"},   32'(ram_enw), 32'd0);
        chk({tag, "_mdata"}, m_data,    32'd0);
        chk({tag, "_mvalid"},32'(m_valid), 32'd0);
        chk({tag, "_mlast"}, 32'(m_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),    32'd0);
        chk({tag, "_err"},   32'(err),     32'd0);
    endtask

    // Statistics of the last transaction
    int n_words, data_bad, last_bad, stall_bad, err_cyc, vld_idle;
    int first_cyc, last_cyc, poll_lat, wr_delta, bad_delta;
    bit timeout;

    task automatic run_txn(input logic [W-1:0] arg, input int rdy_pct, input bit cpu_start);
        int  cyc, tail, wr0, bad0;
        bit  seen_busy, done, prev_stall, prev_last;
        logic [W-1:0] prev_dat, ix;
        n_words = 0; data_bad = 0; last_bad = 0; stall_bad = 0; err_cyc = 0; vld_idle = 0;
        first_cyc = -1; last_cyc = -1; poll_lat = -1; timeout = 0;
        wr0 = wr_total; bad0 = bad_wr;
        seen_busy = 0; done = 0; prev_stall = 0; prev_last = 0; prev_dat = '0;
        tail = 0; cyc = 0;
        arg_word = arg;
        if (cpu_start) cpu_write(32'(CMD_START));
        while (tail < 20) begin
            if (cyc > 3000) begin
                timeout = 1;
                break;
            end
            if (!seen_busy && busy) begin
                seen_busy = 1;
                poll_lat  = cyc;
            end
            if (seen_busy && !busy) done = 1;
            if (err) err_cyc++;
            if (m_valid && !busy) vld_idle++;
            if (prev_stall && (!m_valid || m_data !== prev_dat || m_last !== prev_last))
                stall_bad++;
            m_ready = ($urandom_range(99) < rdy_pct);
            if (m_valid && m_ready) begin
                ix = arg + 32'(n_words);
                if (ix >= 32'(RAM_WORDS) || m_data !== pat(int'(ix))) data_bad++;
                if (m_last !== (n_words == BW - 1)) last_bad++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_words++;
            end
            prev_stall = m_valid && !m_ready;
            prev_dat   = m_data;
            prev_last  = m_last;
            tick();
            cyc++;
            if (done) tail++;
        end
        m_ready   = 1'b0;
        wr_delta  = wr_total - wr0;
        bad_delta = bad_wr - bad0;
    endtask

    task automatic check_run(input string tag, input int exp_words, input logic [W-1:0] exp_ctrl,
                             input int exp_wr, input int exp_err, input int lat_lo, input int lat_hi,
                             input bit chk_tput);
        chk({tag, "_timeout"},  32'(timeout), 32'd0);
        chk({tag, "_poll_lat"}, 32'(poll_lat >= lat_lo && poll_lat <= lat_hi), 32'd1);
        chk({tag, "_words"},    32'(n_words), 32'(exp_words));
        chk({tag, "_data"},     32'(data_bad), 32'd0);
        chk({tag, "_last"},     32'(last_bad), 32'd0);
        chk({tag, "_stall"},    32'(stall_bad), 32'd0);
        chk({tag, "_errcyc"},   32'(err_cyc), 32'(exp_err));
        chk({tag, "_vld_idle"}, 32'(vld_idle), 32'd0);
        chk({tag, "_ctrl"},     ctrl, exp_ctrl);
        chk({tag, "_status_wr"},32'(wr_delta), 32'(exp_wr));
        chk({tag, "_stray_wr"}, 32'(bad_delta), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (chk_tput)
            chk({tag, "_tput"}, 32'(last_cyc - first_cyc), 32'(BW - 1));
    endtask

    typedef struct {
        logic [W-1:0] arg;
        int           rdy_pct;
        bit           drop;
        int           exp_words;
        logic [W-1:0] exp_ctrl;
        int           exp_wr;
        int           exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int guard, cnt, idle_enw0, idle_vld, idle_busy, idle_addr;

        vecs[0] = '{arg: 32'd0,          rdy_pct: 100, drop: 0, exp_words: 64, exp_ctrl: 32'd2, exp_wr: 1, exp_err: 0};
        vecs[1] = '{arg: 32'd1136,       rdy_pct: 50,  drop: 0, exp_words: 64, exp_ctrl: 32'd2, exp_wr: 1, exp_err: 0};
        vecs[2] = '{arg: 32'd1137,       rdy_pct: 100, drop: 0, exp_words: 0,  exp_ctrl: 32'd3, exp_wr: 1, exp_err: 1};
        vecs[3] = '{arg: 32'd0,          rdy_pct: 100, drop: 1, exp_words: 64, exp_ctrl: 32'd2, exp_wr: 2, exp_err: 0};
        vecs[4] = '{arg: 32'hFFFF_FFFF,  rdy_pct: 100, drop: 0, exp_words: 0,  exp_ctrl: 32'd3, exp_wr: 1, exp_err: 1};
        vecs[5] = '{arg: 32'd500,        rdy_pct: 30,  drop: 0, exp_words: 64, exp_ctrl: 32'd2, exp_wr: 1, exp_err: 0};

        for (int i = 0; i < RAM_WORDS; i++) mem[i] = pat(i);

        rst = 1'b1;
        m_ready = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // CTRL=0 for 100 cycles: no activity besides polling CTRL
        idle_enw0 = wr_total + bad_wr;
        idle_vld = 0; idle_busy = 0; idle_addr = 0;
        for (int c = 0; c < 100; c++) begin
            if (m_valid) idle_vld++;
            if (busy) idle_busy++;
            if (ram_addr != 32'(CTRL_ADDR)) idle_addr++;
            tick();
        end
        chk("idle_enw",   32'(wr_total + bad_wr - idle_enw0), 32'd0);
        chk("idle_valid", 32'(idle_vld), 32'd0);
        chk("idle_busy",  32'(idle_busy), 32'd0);
        chk("idle_addr",  32'(idle_addr), 32'd0);

        for (int v = 0; v < 6; v++) begin
            drop_idx = vecs[v].drop ? wr_total : -1;
            run_txn(vecs[v].arg, vecs[v].rdy_pct, 1'b1);
            drop_idx = -1;
            check_run($sformatf("vec%0d", v), vecs[v].exp_words, vecs[v].exp_ctrl,
                      vecs[v].exp_wr, vecs[v].exp_err, 1, PGAP,
                      vecs[v].rdy_pct == 100 && vecs[v].exp_words == BW);
        end

        // Reset after word 20 is accepted, then restart from the still-pending command
        arg_word = 32'd0;
        cpu_write(32'(CMD_START));
        m_ready = 1'b1;
        cnt = 0; guard = 0;
        while (cnt < 21 && guard < 500) begin
            if (m_valid && m_ready) cnt++;
            tick();
            guard++;
        end
        chk("rstmid_reach", 32'(cnt), 32'd21);
        rst = 1'b1;
        m_ready = 1'b0;
        tick();
        check_idle_outputs("rstmid");
        rst = 1'b0;
        chk("rstmid_ctrl_kept", ctrl, 32'(CMD_START));
        run_txn(32'd0, 100, 1'b0);
        check_run("restart", BW, 32'd2, 1, 0, PGAP, PGAP, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
